qbu_tx_ptp_ts_detect: RTL and testbench
=======================================

Name: qbu_tx_ptp_ts_detect

Overview:
- Parametrised successor of the TX-side PTP timestamp trigger in the qbu_tx path.
- Snoops the outgoing MAC AXI-stream (any byte-multiple width) for L2 PTP frames (EtherType 0x88F7), untagged or single-tagged (TPID 0x8100/0x88A8).
- Raises a one-cycle timestamp IRQ carrying frame sequence, PTP messageType and a timestamp-RAM slot address.
- Owns a ring of 2^ADDR_WIDTH slots, with occupancy tracking and ack-based slot release.

Parameters:
- DWIDTH, 8, stream width in bits; legal values 8/16/32/64.
- ADDR_WIDTH, 8, timestamp RAM address width; DEPTH = 2^ADDR_WIDTH slots.
- SEQ_WIDTH, 8, frame sequence counter width.
- ETH_OFFSET, 12, byte index of the first EtherType/TPID byte (byte 0 = first byte of the frame).

Ports:
- i_clk  in  1  clock
- i_rst  in  1  async reset, active-high
- i_mac_axis_data  in  DWIDTH  stream data; lane 0 = bits [DWIDTH-1:DWIDTH-8] = lowest byte index (network order)
- i_mac_axis_keep  in  DWIDTH/8  byte-lane valid; may be partial only on the last beat
- i_mac_axis_valid  in  1  beat valid
- i_mac_axis_last  in  1  last beat of frame
- i_ts_en  in  1  timestamp enable, sampled on the first beat of each frame
- i_msg_type_mask  in  16  bit n set = messageType n triggers; typical value 16'h000D (types 0, 2, 3)
- i_ts_ack  in  1  one-cycle pulse: consumer has read the oldest slot
- o_mac_time_irq  out  1  timestamp trigger pulse
- o_mac_frame_seq  out  SEQ_WIDTH  sequence number of the frame that triggered
- o_ptp_msg_type  out  4  messageType of the triggering frame
- o_timestamp_addr  out  ADDR_WIDTH  slot allocated to this trigger
- o_ts_count  out  ADDR_WIDTH+1  occupied slots
- o_ts_full  out  1  o_ts_count == DEPTH
- o_ts_overflow  out  1  pulse: trigger dropped because the ring is full

Behaviour:
- Reset: all outputs 0. Internal seq counter, write pointer, beat counter, parse state and input registers all 0.
- Stage 0 registers data/keep/valid/last. All parsing runs on the registered beat.
- Byte index of lane k in beat n = n*(DWIDTH/8)+k. The beat counter clears after a beat with last=1; frames are delimited by last, not valid gaps. Valid gaps inside a frame are legal and hold all state.
- Per-frame parse FSM:
  - IDLE -> TYPE on the first valid beat. Latch i_ts_en into the frame-enable flag.
  - TYPE: capture bytes ETH_OFFSET..+1. If 0x8100/0x88A8 -> VLAN; if 0x88F7 -> MSG at index ETH_OFFSET+2; otherwise -> SKIP.
  - VLAN: capture bytes ETH_OFFSET+4..+5. If 0x88F7 -> MSG at index ETH_OFFSET+6; otherwise -> SKIP.
  - MSG: messageType = low nibble of the target byte. Fire if frame-enable=1 and i_msg_type_mask[type]=1. Then -> SKIP.
  - SKIP: wait for last, then -> IDLE.
  - Any state + last -> IDLE in the same cycle; the frame-sequence update is applied as well.
- Lanes with keep=0 are never captured. A frame ending before the messageType byte (runt) produces no IRQ.
- Several fields can fall in one beat (e.g. DWIDTH=64 holds EtherType and messageType). Resolve all of them combinationally within that beat; no extra cycle is spent.
- Fire latency: o_mac_time_irq is high exactly one cycle, registered, 2 cycles after the input beat carrying the messageType byte. Max one fire per frame.
- o_mac_frame_seq / o_ptp_msg_type / o_timestamp_addr update with the IRQ and hold until the next IRQ.
- Frame sequence: the internal counter increments once per frame, on the last beat, wrapping modulo 2^SEQ_WIDTH. The IRQ reports the current frame's value, before the increment.
- Slot ring:
  - A fire with count < DEPTH outputs the current write pointer, then the pointer increments (wrapping modulo DEPTH) and count increments.
  - A fire with count == DEPTH does not assert the IRQ. It pulses o_ts_overflow instead (same timing); pointer and count are unchanged.
- Ack:
  - Decrements count.
  - Ack with count == 0 is ignored.
  - Fire and ack in the same cycle leave count unchanged; this also holds when the ring is full, because the ack is evaluated first and a slot is freed.
- Reset mid-frame: everything clears asynchronously. The next beat after release is treated as a frame start.

Decomposition:
- Shared package qbu_pkg: PTP_ETHERTYPE=16'h88F7, TPID_CTAG=16'h8100, TPID_STAG=16'h88A8, the parse-state enum (IDLE/TYPE/VLAN/MSG/SKIP), and MSG_TYPE_W=4.
- One sub-module, qbu_ts_slot_ring: write pointer, occupancy, full/overflow, ack. It is reused by the RX timestamp path.

Test Plan:
- DWIDTH=8, untagged Sync (0x88F7, byte 14 = 0x10, mask 0x000D) -> one IRQ 2 cycles after byte 14; msg_type=0, addr=0, seq=0. Next such frame -> addr=1, seq=1.
- DWIDTH=32, C-tagged Delay_Req (0x8100 tag, then 0x88F7, byte 18 = 0x01) -> IRQ with msg_type=1 when mask=0x0002; no IRQ when mask=0x000D; seq still advances.
- DWIDTH=64, Follow_Up (type 8), mask 0x000D -> no IRQ. Non-PTP frame (0x0800) -> no IRQ. Runt of 14 bytes with last on byte 13 -> no IRQ, seq +1.
- ADDR_WIDTH=2: 5 Sync frames without ack -> 4 IRQs at addr 0,1,2,3, o_ts_full=1, 5th gives o_ts_overflow and no IRQ. One ack -> count 3; next Sync -> addr 0 (wrap).
- Ack coinciding with fire at count 4 -> count stays 4, IRQ asserted. Ack at count 0 -> count stays 0.
- i_ts_en dropped mid-frame after the first beat -> the frame still fires. Async reset asserted mid-frame -> all outputs 0; next frame parses from byte 0 with seq=0.

Source files
------------

// File: rtl/qbu_pkg.sv
// Shared PTP parse definitions for the qbu TX/RX timestamp paths.
package qbu_pkg;

   localparam logic [15:0] PTP_ETHERTYPE = 16'h88F7;
   localparam logic [15:0] TPID_CTAG     = 16'h8100;
   localparam logic [15:0] TPID_STAG     = 16'h88A8;
   localparam int          MSG_TYPE_W    = 4;

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      TYPE = 3'd1,
      VLAN = 3'd2,
      MSG  = 3'd3,
      SKIP = 3'd4
   } parse_state_e;

endpackage

// File: rtl/qbu_ts_slot_ring.sv
// Timestamp-RAM slot ring: write pointer, occupancy and ack-based release.
// Shared by the TX and RX timestamp paths.
module qbu_ts_slot_ring #(
   parameter int ADDR_WIDTH = 8
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  fire_i,
   input  logic                  ack_i,
   output logic                  grant_o,
   output logic                  overflow_o,
   output logic [ADDR_WIDTH-1:0] slot_o,
   output logic [ADDR_WIDTH:0]   count_o,
   output logic                  full_o
);

   localparam logic [ADDR_WIDTH:0] DEPTH_C = {1'b1, {ADDR_WIDTH{1'b0}}};

   logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
   logic [ADDR_WIDTH:0]   count_q, count_d;
   logic                  ack_eff_s, space_s, grant_s;

   // Ack is resolved before the fire so a full ring can still accept a same-cycle fire.
   always_comb begin
      ack_eff_s = ack_i && (count_q != '0);
      space_s   = (count_q != DEPTH_C) || ack_eff_s;
      grant_s   = fire_i && space_s;
      wr_ptr_d  = wr_ptr_q;
      count_d   = count_q;
      if (grant_s) begin
         wr_ptr_d = wr_ptr_q + ADDR_WIDTH'(1);
      end else begin
         wr_ptr_d = wr_ptr_q;
      end
      if (grant_s && !ack_eff_s) begin
         count_d = count_q + (ADDR_WIDTH+1)'(1);
      end else if (!grant_s && ack_eff_s) begin
         count_d = count_q - (ADDR_WIDTH+1)'(1);
      end else begin
         count_d = count_q;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         wr_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         count_q  <= count_d;
      end
   end

   assign grant_o    = grant_s;
   assign overflow_o = fire_i && !space_s;
   assign slot_o     = wr_ptr_q;
   assign count_o    = count_q;
   assign full_o     = (count_q == DEPTH_C);

endmodule

// File: rtl/qbu_tx_ptp_ts_detect.sv
// TX-side PTP timestamp trigger: snoops the MAC stream for L2 PTP frames
// (untagged or single-tagged) and allocates a timestamp slot per trigger.
module qbu_tx_ptp_ts_detect import qbu_pkg::*; #(
   parameter int DWIDTH     = 8,
   parameter int ADDR_WIDTH = 8,
   parameter int SEQ_WIDTH  = 8,
   parameter int ETH_OFFSET = 12
) (
   input  logic                  i_clk,
   input  logic                  i_rst,
   input  logic [DWIDTH-1:0]     i_mac_axis_data,
   input  logic [DWIDTH/8-1:0]   i_mac_axis_keep,
   input  logic                  i_mac_axis_valid,
   input  logic                  i_mac_axis_last,
   input  logic                  i_ts_en,
   input  logic [15:0]           i_msg_type_mask,
   input  logic                  i_ts_ack,
   output logic                  o_mac_time_irq,
   output logic [SEQ_WIDTH-1:0]  o_mac_frame_seq,
   output logic [MSG_TYPE_W-1:0] o_ptp_msg_type,
   output logic [ADDR_WIDTH-1:0] o_timestamp_addr,
   output logic [ADDR_WIDTH:0]   o_ts_count,
   output logic                  o_ts_full,
   output logic                  o_ts_overflow
);

   localparam int          NB        = DWIDTH / 8;
   localparam int          BCW       = 16;
   localparam logic [31:0] IDX_ET_HI = 32'(ETH_OFFSET);
   localparam logic [31:0] IDX_ET_LO = 32'(ETH_OFFSET + 1);
   localparam logic [31:0] IDX_MSG_U = 32'(ETH_OFFSET + 2);
   localparam logic [31:0] IDX_VT_HI = 32'(ETH_OFFSET + 4);
   localparam logic [31:0] IDX_VT_LO = 32'(ETH_OFFSET + 5);
   localparam logic [31:0] IDX_MSG_T = 32'(ETH_OFFSET + 6);

   logic [DWIDTH-1:0]     data_q;
   logic [NB-1:0]         keep_q;
   logic                  valid_q, last_q, ts_en_q;
   logic [BCW-1:0]        beat_q, beat_d;
   parse_state_e          state_q, state_d, st_s;
   logic                  frame_en_q, frame_en_d, en_s;
   logic                  tagged_q, tagged_d;
   logic [7:0]            et_hi_q, et_hi_d, vt_hi_q, vt_hi_d;
   logic [SEQ_WIDTH-1:0]  seq_q, seq_d;
   logic [7:0]            lane_s, et_lo_s, vt_lo_s;
   logic [31:0]           idx_s;
   logic [3:0]            msg_u_s, msg_t_s, msg_type_s;
   logic                  et_lo_hit_s, vt_lo_hit_s, msg_u_hit_s, msg_t_hit_s;
   logic                  fire_s, grant_s, ovf_s;
   logic [ADDR_WIDTH-1:0] slot_s;
   logic                  irq_q, ovf_q;
   logic [SEQ_WIDTH-1:0]  seq_out_q;
   logic [3:0]            type_out_q;
   logic [ADDR_WIDTH-1:0] addr_out_q;

   // Input stage; the enable is registered with the beat so it lines up with the frame start.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         data_q  <= '0;
         keep_q  <= '0;
         valid_q <= 1'b0;
         last_q  <= 1'b0;
         ts_en_q <= 1'b0;
      end else begin
         data_q  <= i_mac_axis_data;
         keep_q  <= i_mac_axis_keep;
         valid_q <= i_mac_axis_valid;
         last_q  <= i_mac_axis_last;
         ts_en_q <= i_ts_en;
      end
   end

   // Field capture then state walk, so every field landing in one beat resolves in that beat.
   always_comb begin
      et_hi_d     = et_hi_q;
      vt_hi_d     = vt_hi_q;
      lane_s      = 8'h00;
      idx_s       = 32'h0;
      et_lo_s     = 8'h00;
      vt_lo_s     = 8'h00;
      msg_u_s     = 4'h0;
      msg_t_s     = 4'h0;
      et_lo_hit_s = 1'b0;
      vt_lo_hit_s = 1'b0;
      msg_u_hit_s = 1'b0;
      msg_t_hit_s = 1'b0;
      for (int k = 0; k < NB; k++) begin
         lane_s = data_q[DWIDTH-1-8*k -: 8];
         idx_s  = 32'(beat_q) * 32'(NB) + 32'(k);
         if (valid_q && keep_q[k]) begin
            if (idx_s == IDX_ET_HI) begin
               et_hi_d = lane_s;
            end else if (idx_s == IDX_ET_LO) begin
               et_lo_s = lane_s;  et_lo_hit_s = 1'b1;
            end else if (idx_s == IDX_MSG_U) begin
               msg_u_s = lane_s[3:0];  msg_u_hit_s = 1'b1;
            end else if (idx_s == IDX_VT_HI) begin
               vt_hi_d = lane_s;
            end else if (idx_s == IDX_VT_LO) begin
               vt_lo_s = lane_s;  vt_lo_hit_s = 1'b1;
            end else if (idx_s == IDX_MSG_T) begin
               msg_t_s = lane_s[3:0];  msg_t_hit_s = 1'b1;
            end else begin
               lane_s = lane_s;
            end
         end else begin
            lane_s = lane_s;
         end
      end

      st_s       = state_q;
      en_s       = frame_en_q;
      tagged_d   = tagged_q;
      fire_s     = 1'b0;
      msg_type_s = 4'h0;
      beat_d     = beat_q;
      seq_d      = seq_q;
      if (valid_q) begin
         if (st_s == IDLE) begin
            st_s     = TYPE;
            en_s     = ts_en_q;
            tagged_d = 1'b0;
         end else begin
            st_s = st_s;
         end
         if (st_s == TYPE && et_lo_hit_s) begin
            if ({et_hi_d, et_lo_s} == TPID_CTAG || {et_hi_d, et_lo_s} == TPID_STAG) begin
               st_s = VLAN;
            end else if ({et_hi_d, et_lo_s} == PTP_ETHERTYPE) begin
               st_s = MSG;
            end else begin
               st_s = SKIP;
            end
         end else begin
            st_s = st_s;
         end
         if (st_s == VLAN && vt_lo_hit_s) begin
            if ({vt_hi_d, vt_lo_s} == PTP_ETHERTYPE) begin
               st_s     = MSG;
               tagged_d = 1'b1;
            end else begin
               st_s = SKIP;
            end
         end else begin
            st_s = st_s;
         end
         if (st_s == MSG && (tagged_d ? msg_t_hit_s : msg_u_hit_s)) begin
            msg_type_s = tagged_d ? msg_t_s : msg_u_s;
            fire_s     = en_s && i_msg_type_mask[msg_type_s];
            st_s       = SKIP;
         end else begin
            st_s = st_s;
         end
         if (last_q) begin
            st_s   = IDLE;
            beat_d = '0;
            seq_d  = seq_q + SEQ_WIDTH'(1);
         end else if (beat_q != {BCW{1'b1}}) begin
            beat_d = beat_q + BCW'(1);
         end else begin
            beat_d = beat_q;
         end
      end else begin
         st_s = state_q;
      end
      state_d    = st_s;
      frame_en_d = en_s;
   end

   // Parse state and per-frame context.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state_q    <= IDLE;
         frame_en_q <= 1'b0;
         tagged_q   <= 1'b0;
         et_hi_q    <= '0;
         vt_hi_q    <= '0;
         beat_q     <= '0;
         seq_q      <= '0;
      end else begin
         state_q    <= state_d;
         frame_en_q <= frame_en_d;
         tagged_q   <= tagged_d;
         et_hi_q    <= et_hi_d;
         vt_hi_q    <= vt_hi_d;
         beat_q     <= beat_d;
         seq_q      <= seq_d;
      end
   end

   qbu_ts_slot_ring #(
      .ADDR_WIDTH (ADDR_WIDTH)
   ) u_ring (
      .clk_i      (i_clk),
      .rst_i      (i_rst),
      .fire_i     (fire_s),
      .ack_i      (i_ts_ack),
      .grant_o    (grant_s),
      .overflow_o (ovf_s),
      .slot_o     (slot_s),
      .count_o    (o_ts_count),
      .full_o     (o_ts_full)
   );

   // Trigger outputs; descriptor fields only move on an accepted trigger.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         irq_q      <= 1'b0;
         ovf_q      <= 1'b0;
         seq_out_q  <= '0;
         type_out_q <= '0;
         addr_out_q <= '0;
      end else begin
         irq_q <= grant_s;
         ovf_q <= ovf_s;
         if (grant_s) begin
            seq_out_q  <= seq_q;
            type_out_q <= msg_type_s;
            addr_out_q <= slot_s;
         end
      end
   end

   assign o_mac_time_irq   = irq_q;
   assign o_ts_overflow    = ovf_q;
   assign o_mac_frame_seq  = seq_out_q;
   assign o_ptp_msg_type   = type_out_q;
   assign o_timestamp_addr = addr_out_q;

endmodule

// File: tb/tb_qbu_tx_ptp_ts_detect.sv
// Directed bench for qbu_tx_ptp_ts_detect: three instances (8/32/64-bit streams),
// the 8-bit one with a 4-slot ring.
module tb_qbu_tx_ptp_ts_detect;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   logic [7:0]  d8;  logic [0:0] k8;  logic v8,  l8;
   logic [31:0] d32; logic [3:0] k32; logic v32, l32;
   logic [63:0] d64; logic [7:0] k64; logic v64, l64;
   logic        ts_en, ack0, ack_off;
   logic [15:0] mask;

   logic irq0, full0, ovf0; logic [7:0] seq0; logic [3:0] typ0; logic [1:0] addr0; logic [2:0] cnt0;
   logic irq1, full1, ovf1; logic [7:0] seq1; logic [3:0] typ1; logic [7:0] addr1; logic [8:0] cnt1;
   logic irq2, full2, ovf2; logic [7:0] seq2; logic [3:0] typ2; logic [7:0] addr2; logic [8:0] cnt2;

   qbu_tx_ptp_ts_detect #(.DWIDTH(8), .ADDR_WIDTH(2), .SEQ_WIDTH(8), .ETH_OFFSET(12)) u_d8 (
      .i_clk(clk), .i_rst(rst), .i_mac_axis_data(d8), .i_mac_axis_keep(k8),
      .i_mac_axis_valid(v8), .i_mac_axis_last(l8), .i_ts_en(ts_en), .i_msg_type_mask(mask),
      .i_ts_ack(ack0), .o_mac_time_irq(irq0), .o_mac_frame_seq(seq0), .o_ptp_msg_type(typ0),
      .o_timestamp_addr(addr0), .o_ts_count(cnt0), .o_ts_full(full0), .o_ts_overflow(ovf0));

   qbu_tx_ptp_ts_detect #(.DWIDTH(32), .ADDR_WIDTH(8), .SEQ_WIDTH(8), .ETH_OFFSET(12)) u_d32 (
      .i_clk(clk), .i_rst(rst), .i_mac_axis_data(d32), .i_mac_axis_keep(k32),
      .i_mac_axis_valid(v32), .i_mac_axis_last(l32), .i_ts_en(ts_en), .i_msg_type_mask(mask),
      .i_ts_ack(ack_off), .o_mac_time_irq(irq1), .o_mac_frame_seq(seq1), .o_ptp_msg_type(typ1),
      .o_timestamp_addr(addr1), .o_ts_count(cnt1), .o_ts_full(full1), .o_ts_overflow(ovf1));

   qbu_tx_ptp_ts_detect #(.DWIDTH(64), .ADDR_WIDTH(8), .SEQ_WIDTH(8), .ETH_OFFSET(12)) u_d64 (
      .i_clk(clk), .i_rst(rst), .i_mac_axis_data(d64), .i_mac_axis_keep(k64),
      .i_mac_axis_valid(v64), .i_mac_axis_last(l64), .i_ts_en(ts_en), .i_msg_type_mask(mask),
      .i_ts_ack(ack_off), .o_mac_time_irq(irq2), .o_mac_frame_seq(seq2), .o_ptp_msg_type(typ2),
      .o_timestamp_addr(addr2), .o_ts_count(cnt2), .o_ts_full(full2), .o_ts_overflow(ovf2));

   int checks = 0;
   int failures = 0;
   int cyc = 0;
   int mcyc = 0;
   int ni0 = 0, ni1 = 0, ni2 = 0, nov0 = 0;
   int ic0 = 0, ic1 = 0, ic2 = 0;
   logic [7:0] fb [0:127];

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (irq0) begin ni0 <= ni0 + 1; ic0 <= cyc; end
      if (irq1) begin ni1 <= ni1 + 1; ic1 <= cyc; end
      if (irq2) begin ni2 <= ni2 + 1; ic2 <= cyc; end
      if (ovf0) nov0 <= nov0 + 1;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic build(input logic [15:0] tpid, input logic [15:0] et, input logic [7:0] msg);
      for (int i = 0; i < 128; i++) fb[i] = 8'(i + 48);
      if (tpid != 16'h0000) begin
         fb[12] = tpid[15:8]; fb[13] = tpid[7:0];
         fb[14] = 8'h00;      fb[15] = 8'h05;
         fb[16] = et[15:8];   fb[17] = et[7:0];
         fb[18] = msg;
      end else begin
         fb[12] = et[15:8];   fb[13] = et[7:0];
         fb[14] = msg;
      end
   endtask

   task automatic drive(input int inst, input logic [63:0] w, input logic [7:0] kp,
                        input logic v, input logic l);
      case (inst)
         0:       begin d8  = w[63:56]; k8  = kp[0:0]; v8  = v; l8  = l; end
         1:       begin d32 = w[63:32]; k32 = kp[3:0]; v32 = v; l32 = l; end
         default: begin d64 = w;        k64 = kp;      v64 = v; l64 = l; end
      endcase
   endtask

   // abort_at>0 stops after that many bytes with no last; lanes past len carry data but keep=0.
   task automatic send(input int inst, input int len, input int mark, input int abort_at,
                       input bit gap, input bit ackfire, input bit en_drop);
      int nb, stop;
      logic [63:0] w;
      logic [7:0] kp;
      logic lst;
      nb   = (inst == 0) ? 1 : ((inst == 1) ? 4 : 8);
      stop = (abort_at > 0) ? abort_at : len;
      for (int b = 0; b * nb < stop; b++) begin
         w = '0; kp = '0;
         for (int k = 0; k < nb; k++) begin
            w[63-8*k -: 8] = fb[b*nb+k];
            if (b * nb + k < len) kp[k] = 1'b1;
         end
         lst = (abort_at == 0) && ((b + 1) * nb >= len);
         drive(inst, w, kp, 1'b1, lst);
         @(posedge clk); #1;
         ack0 = 1'b0;
         if (b == 0 && en_drop) ts_en = 1'b0;
         if (mark >= b * nb && mark < (b + 1) * nb) begin
            mcyc = cyc;
            if (ackfire) ack0 = 1'b1;
         end
         if (gap) begin
            drive(inst, w, kp, 1'b0, 1'b0);
            @(posedge clk); #1;
            ack0 = 1'b0;
         end
      end
      drive(inst, 64'h0, 8'h00, 1'b0, 1'b0);
      repeat (4) begin @(posedge clk); #1; ack0 = 1'b0; end
   endtask

   task automatic ack_pulse();
      ack0 = 1'b1;
      @(posedge clk); #1;
      ack0 = 1'b0;
      @(posedge clk); #1;
   endtask

   initial begin
      rst = 1'b1; ts_en = 1'b1; mask = 16'h000D; ack0 = 1'b0; ack_off = 1'b0;
      drive(0, 64'h0, 8'h00, 1'b0, 1'b0);
      drive(1, 64'h0, 8'h00, 1'b0, 1'b0);
      drive(2, 64'h0, 8'h00, 1'b0, 1'b0);
      repeat (3) @(posedge clk); #1;
      chk("rst_irq",  irq0,  0); chk("rst_seq",  seq0, 0); chk("rst_type", typ0, 0);
      chk("rst_addr", addr0, 0); chk("rst_cnt",  cnt0, 0); chk("rst_full", full0, 0);
      chk("rst_ovf",  ovf0,  0); chk("rst_irq64", irq2, 0); chk("rst_cnt32", cnt1, 0);
      rst = 1'b0;
      @(posedge clk); #1;

      // 8-bit untagged Sync, latency and first slot
      build(16'h0000, 16'h88F7, 8'h10);
      send(0, 60, 14, 0, 1'b0, 1'b0, 1'b0);
      chk("d8_sync_n", ni0, 1);      chk("d8_sync_lat", ic0, mcyc + 1);
      chk("d8_sync_type", typ0, 0);  chk("d8_sync_addr", addr0, 0);
      chk("d8_sync_seq", seq0, 0);   chk("d8_sync_cnt", cnt0, 1);
      send(0, 60, 14, 0, 1'b1, 1'b0, 1'b0);
      chk("d8_gap_n", ni0, 2); chk("d8_gap_addr", addr0, 1);
      chk("d8_gap_seq", seq0, 1); chk("d8_gap_cnt", cnt0, 2);

      ack_pulse(); ack_pulse();
      chk("ack_drain", cnt0, 0);
      ack_pulse();
      chk("ack_at_zero", cnt0, 0);

      for (int j = 0; j < 4; j++) begin
         send(0, 60, 14, 0, 1'b0, 1'b0, 1'b0);
         chk("ring_addr", addr0, (2 + j) % 4);
         chk("ring_seq", seq0, 2 + j);
      end
      chk("ring_n", ni0, 6); chk("ring_cnt", cnt0, 4); chk("ring_full", full0, 1);
      send(0, 60, 14, 0, 1'b0, 1'b0, 1'b0);
      chk("ovf_no_irq", ni0, 6);  chk("ovf_pulse", nov0, 1);
      chk("ovf_seq_hold", seq0, 5); chk("ovf_addr_hold", addr0, 1); chk("ovf_cnt", cnt0, 4);
      ack_pulse();
      chk("ack_cnt3", cnt0, 3); chk("ack_not_full", full0, 0);
      send(0, 60, 14, 0, 1'b0, 1'b0, 1'b0);
      chk("wrap_addr", addr0, 2); chk("wrap_seq", seq0, 7); chk("wrap_cnt", cnt0, 4);
      send(0, 60, 14, 0, 1'b0, 1'b1, 1'b0);
      chk("ackfire_n", ni0, 8); chk("ackfire_addr", addr0, 3); chk("ackfire_seq", seq0, 8);
      chk("ackfire_cnt", cnt0, 4); chk("ackfire_no_ovf", nov0, 1);
      repeat (4) ack_pulse();
      chk("drain_cnt", cnt0, 0);

      send(0, 60, 14, 0, 1'b0, 1'b0, 1'b1);
      ts_en = 1'b1;
      chk("endrop_n", ni0, 9); chk("endrop_addr", addr0, 0); chk("endrop_seq", seq0, 9);
      ts_en = 1'b0;
      send(0, 60, 14, 0, 1'b0, 1'b0, 1'b0);
      ts_en = 1'b1;
      chk("disabled_n", ni0, 9); chk("disabled_seq_hold", seq0, 9);

      // 32-bit C-tagged Delay_Req, then masked out, then S-tagged Sync
      mask = 16'h0002;
      build(16'h8100, 16'h88F7, 8'h01);
      send(1, 61, 18, 0, 1'b0, 1'b0, 1'b0);
      chk("d32_dreq_n", ni1, 1);  chk("d32_dreq_lat", ic1, mcyc + 1);
      chk("d32_dreq_type", typ1, 1); chk("d32_dreq_seq", seq1, 0); chk("d32_dreq_addr", addr1, 0);
      mask = 16'h000D;
      send(1, 61, 18, 0, 1'b0, 1'b0, 1'b0);
      chk("d32_masked_n", ni1, 1);
      build(16'h88A8, 16'h88F7, 8'h00);
      send(1, 61, 18, 0, 1'b0, 1'b0, 1'b0);
      chk("d32_stag_n", ni1, 2); chk("d32_stag_seq", seq1, 2);
      chk("d32_stag_addr", addr1, 1); chk("d32_stag_type", typ1, 0); chk("d32_cnt", cnt1, 2);

      // 64-bit: rejects, runt, then fires with several fields per beat
      build(16'h0000, 16'h88F7, 8'h08);
      send(2, 64, 14, 0, 1'b0, 1'b0, 1'b0);
      chk("d64_followup_n", ni2, 0);
      build(16'h0000, 16'h0800, 8'h00);
      send(2, 64, 14, 0, 1'b0, 1'b0, 1'b0);
      chk("d64_ipv4_n", ni2, 0);
      build(16'h0000, 16'h88F7, 8'h00);
      send(2, 14, 14, 0, 1'b0, 1'b0, 1'b0);
      chk("d64_runt_n", ni2, 0);
      send(2, 64, 14, 0, 1'b0, 1'b0, 1'b0);
      chk("d64_sync_n", ni2, 1); chk("d64_sync_lat", ic2, mcyc + 1);
      chk("d64_sync_seq", seq2, 3); chk("d64_sync_addr", addr2, 0); chk("d64_sync_type", typ2, 0);
      build(16'h8100, 16'h88F7, 8'h02);
      send(2, 64, 18, 0, 1'b0, 1'b0, 1'b0);
      chk("d64_tag_n", ni2, 2); chk("d64_tag_type", typ2, 2);
      chk("d64_tag_seq", seq2, 4); chk("d64_tag_addr", addr2, 1);

      // async reset in the middle of a frame
      build(16'h0000, 16'h88F7, 8'h13);
      send(0, 60, 14, 10, 1'b0, 1'b0, 1'b0);
      #2 rst = 1'b1;
      #1;
      chk("mid_rst_cnt", cnt0, 0); chk("mid_rst_seq", seq0, 0);
      chk("mid_rst_irq", irq0, 0); chk("mid_rst_seq64", seq2, 0);
      @(posedge clk); #1;
      rst = 1'b0;
      @(posedge clk); #1;
      send(0, 60, 14, 0, 1'b0, 1'b0, 1'b0);
      chk("post_rst_n", ni0, 10); chk("post_rst_seq", seq0, 0);
      chk("post_rst_addr", addr0, 0); chk("post_rst_type", typ0, 3); chk("post_rst_cnt", cnt0, 1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
